signed_diff_bcd_converter: RTL and testbench
============================================

SIGNED_DIFF_BCD_CONVERTER -- requirements
Module: signed_diff_bcd_converter

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose these ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- Start_in, input, 1: request conversion of the current inputs.
- Diff_in16, input, 16: raw difference from the 16-bit subtractor stage, unmodified when negative.
- Is_negative_in, input, 1: sign flag from the subtractor stage.
- Busy_out, output, 1: conversion in progress.
- Done_out, output, 1: one-cycle pulse when the result is valid.
- Sign_out, output, 1: result is negative.
- BCD_out20, output, 20: five BCD digits; [3:0] is ones, [19:16] is ten-thousands.
- Blank_out5, output, 5: per-digit leading-zero blank mask; bit i covers digit i.

Function
REQ-003 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-004 IDLE: Start_in=1 SHALL capture Diff_in16 and Is_negative_in and move to LOAD.
REQ-005 LOAD (1 cycle): magnitude SHALL be ~Diff_in16+1 (16-bit, carry discarded) if negative, else Diff_in16; SHALL clear the BCD accumulator and load shift count 16.
REQ-006 SHIFT (16 cycles): each cycle, add 3 to every accumulator digit >=5, then shift {accumulator, magnitude} left by 1 and decrement the count.
REQ-007 SHALL go SHIFT->DONE when the count reaches 0; DONE lasts 1 cycle, then returns to IDLE.
REQ-008 In DONE, SHALL register BCD_out20, Sign_out and Blank_out5 and pulse Done_out=1.
REQ-009 Latency SHALL be 18 cycles from the cycle Start_in is sampled to Done_out=1; throughput is 1 conversion per 19 cycles.
REQ-010 Busy_out SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-011 Start_in SHALL be ignored while Busy_out=1; the conversion is not aborted or queued.
REQ-012 Start_in in the same cycle DONE returns to IDLE SHALL be ignored; it is sampled only in IDLE.
REQ-013 Outputs SHALL hold their last result until the next DONE.
REQ-014 Is_negative_in=1 with Diff_in16=0 SHALL yield Sign_out=0, BCD 00000 (no negative zero).
REQ-015 Maximum magnitude is 65535; the ten-thousands digit SHALL never exceed 6.

Reset
REQ-016 rst_n=0 SHALL immediately force state IDLE and set Busy_out, Done_out and Sign_out to 0, BCD_out20=0 and Blank_out5=0, plus all internal registers to 0.
REQ-017 Reset asserted mid-conversion SHALL abort it with no Done_out pulse; the first Start_in after release SHALL be honoured.

Configuration
REQ-018 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL set Blank_out5 bit i in DONE for every digit above the most-significant nonzero digit; bit 0 is never set.
REQ-019 Without LEADING_ZERO_BLANK_EN, the Blank_out5 port SHALL remain present, driven constant 0, with no blanking logic.

Structure
REQ-020 A shared package SHALL hold the state enum, DIFF_WIDTH=16, BCD_DIGITS=5 and SHIFT_COUNT=16.
REQ-021 SHALL instantiate one sub-module, dabble_correct_4 (4-bit add-3-if->=5), five times.

Verification
REQ-022 Diff=0x3039, neg=0, Start -> 18 cycles later Done=1, BCD=0x12345, Sign=0, Blank=00000.
REQ-023 Diff=0xFFFF, neg=1 -> BCD=0x00001, Sign=1, Blank=11110 (with macro) / 00000 (without).
REQ-024 Diff=0xFFFF, neg=0 -> BCD=0x65535, Sign=0; Diff=0, neg=1 -> BCD=0, Sign=0, Blank=11110 (with macro).
REQ-025 Start held high continuously -> Done pulses every 19 cycles; Start pulses during Busy -> ignored, prior result unchanged.
REQ-026 rst_n low during SHIFT cycle 8 -> Busy=0 immediately, no Done; Start with Diff=0x0064 after release -> BCD=0x00100.

Source files
------------

// File: rtl/signed_diff_bcd_converter_pkg.sv
// Shared types and sizing for the signed difference to BCD converter.
package signed_diff_bcd_converter_pkg;

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   localparam int unsigned DIFF_WIDTH  = 16;
   localparam int unsigned BCD_DIGITS  = 5;
   localparam int unsigned SHIFT_COUNT = 16;
   localparam int unsigned BCD_WIDTH   = 4 * BCD_DIGITS;
   localparam int unsigned CNT_WIDTH   = $clog2(SHIFT_COUNT + 1);

endpackage

// File: rtl/signed_diff_bcd_converter_dabble_correct_4.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before shifting.
module dabble_correct_4 (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/signed_diff_bcd_converter.sv
// Sign/magnitude conversion of a 16-bit two's-complement difference to five BCD digits.
// Define LEADING_ZERO_BLANK_EN to drive the leading-zero blank mask on Blank_out5.
module signed_diff_bcd_converter
   import signed_diff_bcd_converter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Start_in,
   input  logic [DIFF_WIDTH-1:0] Diff_in16,
   input  logic                  Is_negative_in,
   output logic                  Busy_out,
   output logic                  Done_out,
   output logic                  Sign_out,
   output logic [BCD_WIDTH-1:0]  BCD_out20,
   output logic [BCD_DIGITS-1:0] Blank_out5
);

   state_e state_q, state_d;

   logic [DIFF_WIDTH-1:0]           diff_q;
   logic                            neg_q;
   logic [DIFF_WIDTH-1:0]           mag_q;
   logic [BCD_WIDTH-1:0]            acc_q;
   logic [CNT_WIDTH-1:0]            cnt_q;
   logic                            done_q;
   logic                            sign_q;
   logic [BCD_WIDTH-1:0]            bcd_q;
   logic [BCD_WIDTH-1:0]            acc_corr;
   logic [BCD_WIDTH+DIFF_WIDTH-1:0] shift_full;

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dabble
      dabble_correct_4 u_dabble (
         .digit_i (acc_q[4*g +: 4]),
         .digit_o (acc_corr[4*g +: 4])
      );
   end

   assign shift_full = {acc_corr, mag_q} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (Start_in) state_d = StLoad;
         StLoad:  state_d = StShift;
         StShift: if (cnt_q == CNT_WIDTH'(1)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q <= '0;
         neg_q  <= 1'b0;
         mag_q  <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
         sign_q <= 1'b0;
         bcd_q  <= '0;
      end else begin
         done_q <= (state_q == StDone);
         unique case (state_q)
            StIdle: begin
               if (Start_in) begin
                  diff_q <= Diff_in16;
                  neg_q  <= Is_negative_in;
               end
            end
            StLoad: begin
               mag_q <= neg_q ? (~diff_q + DIFF_WIDTH'(1)) : diff_q;
               acc_q <= '0;
               cnt_q <= CNT_WIDTH'(SHIFT_COUNT);
            end
            StShift: begin
               acc_q <= shift_full[BCD_WIDTH+DIFF_WIDTH-1 -: BCD_WIDTH];
               mag_q <= shift_full[DIFF_WIDTH-1:0];
               cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
            StDone: begin
               bcd_q  <= acc_q;
               // A negative zero is reported as positive.
               sign_q <= neg_q && (diff_q != '0);
            end
            default: ;
         endcase
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [BCD_DIGITS-1:0] blank_q, blank_d;
   logic                  upper_zero;

   // Ones digit is never blanked so a zero result still shows "0".
   always_comb begin
      blank_d    = '0;
      upper_zero = 1'b1;
      for (int i = BCD_DIGITS - 1; i > 0; i--) begin
         upper_zero = upper_zero && (acc_q[4*i +: 4] == 4'd0);
         blank_d[i] = upper_zero;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_q <= '0;
      end else if (state_q == StDone) begin
         blank_q <= blank_d;
      end
   end

   assign Blank_out5 = blank_q;
`else
   assign Blank_out5 = '0;
`endif

   assign Busy_out  = (state_q != StIdle);
   assign Done_out  = done_q;
   assign Sign_out  = sign_q;
   assign BCD_out20 = bcd_q;

endmodule

// File: tb/tb_signed_diff_bcd_converter.sv
// Scoreboard bench for signed_diff_bcd_converter: expected results queued at start, checked on Done.
module tb_signed_diff_bcd_converter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] diff;
   logic        is_neg;
   logic        busy;
   logic        done;
   logic        sign;
   logic [19:0] bcd;
   logic [4:0]  blank;

   always #5 clk = ~clk;

   signed_diff_bcd_converter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .Start_in       (start),
      .Diff_in16      (diff),
      .Is_negative_in (is_neg),
      .Busy_out       (busy),
      .Done_out       (done),
      .Sign_out       (sign),
      .BCD_out20      (bcd),
      .Blank_out5     (blank)
   );

   typedef struct {
      logic [19:0] bcd;
      logic        sign;
      logic [4:0]  blank;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] d, input logic neg);
      exp_t e;
      int   mag;
      int   m;
      int   nd;
      mag = neg ? ((65536 - int'(d)) % 65536) : int'(d);
      m   = mag;
      e.bcd = '0;
      for (int i = 0; i < 5; i++) begin
         e.bcd[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      e.sign  = neg && (d != 16'd0);
      e.blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
      nd = (mag >= 10000) ? 5 : (mag >= 1000) ? 4 : (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
      for (int i = 0; i < 5; i++) if (i >= nd) e.blank[i] = 1'b1;
`else
      nd = 0;
`endif
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_val("bcd", 32'(bcd), 32'(e.bcd));
            check_val("sign", 32'(sign), 32'(e.sign));
            check_val("blank", 32'(blank), 32'(e.blank));
         end
      end
   end

   task automatic convert(input logic [15:0] d, input logic neg);
      int lat;
      @(negedge clk);
      diff   = d;
      is_neg = neg;
      start  = 1'b1;
      sb_q.push_back(model(d, neg));
      @(posedge clk);
      #1 start = 1'b0;
      check_val("busy_after_start", 32'(busy), 32'd1);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
      check_val("latency", lat, 18);
      check_val("idle_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t[3];
      int n;
      rst_n  = 1'b0;
      start  = 1'b0;
      diff   = '0;
      is_neg = 1'b0;
      #12;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_sign", 32'(sign), 32'd0);
      check_val("rst_bcd", 32'(bcd), 32'd0);
      check_val("rst_blank", 32'(blank), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      convert(16'h3039, 1'b0);
      convert(16'hFFFF, 1'b1);
      convert(16'hFFFF, 1'b0);
      convert(16'h0000, 1'b1);
      convert(16'h8000, 1'b1);
      convert(16'h0009, 1'b0);
      for (int r = 0; r < 6; r++) begin
         convert(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      end

      // Start pulses while busy must be ignored and the result must hold afterwards.
      convert(16'h0100, 1'b0);
      @(negedge clk);
      diff   = 16'h0001;
      is_neg = 1'b0;
      start  = 1'b1;
      sb_q.push_back(model(16'h0001, 1'b0));
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      diff  = 16'h2222;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      check_val("ignored_start_sb", sb_q.size(), 0);
      check_val("hold_bcd", 32'(bcd), 32'h00001);
      check_val("hold_busy", 32'(busy), 32'd0);

      // Start held high: three back-to-back conversions.
      @(negedge clk);
      diff   = 16'h0001;
      is_neg = 1'b1;
      for (int i = 0; i < 3; i++) sb_q.push_back(model(16'h0001, 1'b1));
      start = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(posedge clk);
         #1;
         if (done) begin
            t[n] = cyc;
            n++;
            if (n == 3) begin
               start = 1'b0;
               break;
            end
         end
      end
      check_val("cont_count", n, 3);
      check_val("cont_first", t[0], 18);
      check_val("cont_period1", t[1] - t[0], 19);
      check_val("cont_period2", t[2] - t[1], 19);
      repeat (25) @(negedge clk);
      check_val("cont_sb", sb_q.size(), 0);

      // Reset during SHIFT cycle 8 aborts without a Done pulse.
      @(negedge clk);
      diff   = 16'h3039;
      is_neg = 1'b0;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_done", 32'(done), 32'd0);
      check_val("abort_bcd", 32'(bcd), 32'd0);
      check_val("abort_sign", 32'(sign), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      check_val("abort_no_done", 32'(done), 32'd0);
      convert(16'h0064, 1'b0);

      repeat (3) @(negedge clk);
      check_val("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
